dcache_mem_fill: RTL and testbench
==================================

Name: dcache_mem_fill

Overview:
- Memory-side counterpart of the D-cache controller's request interface.
- Accepts BUS_LOAD/BUS_STORE requests on proc2Dmem_*, buffers one request and drives it onto the tagged memory bus until memory accepts it.
- Tracks outstanding load misses in a small MSHR table and matches returning memory tags to them.
- Produces the Dmem2proc_idx/tag/data/valid fill that writes the block into the D-cache.

Parameters:
- N_MSHR, 4, number of outstanding load-miss entries (power of 2, 2..8)
- MEM_TAG_W, 4, width of the memory transaction tag; tag 0 means "none"

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- proc2Dmem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from the D-cache controller
- proc2Dmem_addr  in  32  byte address of the request
- proc2Dmem_size  in  2  BYTE/HALF/WORD/DOUBLE
- proc2Dmem_data  in  64  store data (already merged to a full block)
- req_ready  out  1  request accepted this cycle; the controller holds the request until it sees this high
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  32  address to memory
- proc2mem_size  out  2  size to memory
- proc2mem_data  out  64  data to memory
- mem2proc_response  in  MEM_TAG_W  nonzero = memory accepted this cycle's command, value = its tag
- mem2proc_tag  in  MEM_TAG_W  nonzero = data for this tag is on mem2proc_data
- mem2proc_data  in  64  returned block
- Dmem2proc_idx  out  5  cache index of the fill (addr[7:3])
- Dmem2proc_tag  out  8  cache tag of the fill (addr[15:8])
- Dmem2proc_data  out  64  fill data
- Dmem2proc_valid  out  1  one-cycle fill strobe
- mshr_full  out  1  all MSHR entries valid

Behaviour:
- Reset values: every output 0, with proc2mem_command = BUS_NONE and proc2mem_size = DOUBLE. Request buffer empty, all MSHR entries invalid.
- Reset mid-operation discards the buffer and all MSHRs. Later tags from memory match nothing and are ignored.
- Request buffer (1 entry):
  - req_ready = command != BUS_NONE && buffer empty && !(command == BUS_LOAD && mshr_full).
  - On req_ready the buffer latches command, addr, size and data.
- Issue:
  - While the buffer is valid, proc2mem_* are driven from it (registered, so first on the bus the cycle after acceptance). Otherwise BUS_NONE, zero addr/data, DOUBLE size.
  - If mem2proc_response != 0 while issuing, the buffer empties at that edge.
  - For a load, the lowest-index free MSHR is written the same edge with {valid, resp tag, addr[31:3]}.
  - A store retires with no tracking.
- Response 0: the request is re-driven unchanged the next cycle, with no limit on retries.
- Fill:
  - When mem2proc_tag != 0 and it equals the tag of a valid MSHR, the Dmem2proc_* outputs are registered at the next edge: valid = 1 for exactly one cycle, idx/tag taken from the stored address, data = mem2proc_data. That MSHR is freed at the same edge.
  - A nonzero tag that matches no entry is ignored.
  - Fill latency: tag seen at cycle F, Dmem2proc_valid high at F+1.
- Simultaneous events:
  - A free and an allocate in the same cycle are both applied.
  - mshr_full and req_ready use the pre-edge state, so a freed entry is usable the following cycle.
  - Fill and acceptance in the same cycle are independent.
- mshr_full is a combinational AND of the valid bits.
- Store accepted behind a pending load to the same block: it is issued in order, with no hazard check (memory is in-order).

Optional Feature:
- Macro: DMEM_MERGE_EN.
- Defined: an incoming BUS_LOAD whose addr[31:3] matches a valid MSHR entry, or a buffered load, is accepted (req_ready = 1, even if mshr_full) but is not buffered or issued. The pending fill covers it.
- Undefined: every load is buffered and issued, and duplicates occupy separate MSHRs and produce separate fills.

Test Plan:
- Reset, then a BUS_LOAD to 0x0000_1238: req_ready = 1 at cycle 0; proc2mem_addr = 0x1238 and command = BUS_LOAD at cycle 1. Response = 3 at cycle 2. mem2proc_tag = 3 with data 0xDEADBEEF_CAFEF00D at cycle 6 → Dmem2proc_valid at cycle 7 only, idx = 7, tag = 0x12, data matches.
- Response 0 for 3 cycles, then 5: request held stable for 4 cycles, one MSHR allocated with tag 5.
- 4 loads to distinct blocks, all accepted: mshr_full = 1, a 5th load sees req_ready = 0. Fill of one tag → req_ready = 1 the cycle after the fill edge.
- BUS_STORE 0x40 with data 0x1122334455667788, response 2: store issued once, no MSHR allocated, no Dmem2proc_valid.
- Out-of-order fills: tags 4 then 1 for loads 0x100 and 0x200 → fills carry idx/tag of 0x200 then 0x100. A stray tag 9 produces no fill.
- DMEM_MERGE_EN defined: two loads to 0x300 and 0x304 → one memory request, one fill. Undefined: two requests, two fills.

Source files
------------

// File: rtl/dcache_mem_fill.sv
// Memory-side fill unit for the D-cache: one-entry request buffer, tagged bus issue,
// MSHR table for load misses and the registered Dmem2proc fill. Optional DMEM_MERGE_EN.
module dcache_mshr_entry #(
  parameter int MEM_TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic                 free,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  logic [28:0]          alloc_blk,
  output logic                 vld,
  output logic [MEM_TAG_W-1:0] tag,
  output logic [28:0]          blk
);
  // alloc only hits a free entry and free only a valid one, so they never collide
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= 1'b0;
      tag <= '0;
      blk <= '0;
    end else if (alloc) begin
      vld <= 1'b1;
      tag <= alloc_tag;
      blk <= alloc_blk;
    end else if (free) begin
      vld <= 1'b0;
    end
  end
endmodule

module dcache_mem_fill #(
  parameter int N_MSHR    = 4,
  parameter int MEM_TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           proc2Dmem_command,
  input  logic [31:0]          proc2Dmem_addr,
  input  logic [1:0]           proc2Dmem_size,
  input  logic [63:0]          proc2Dmem_data,
  output logic                 req_ready,
  output logic [1:0]           proc2mem_command,
  output logic [31:0]          proc2mem_addr,
  output logic [1:0]           proc2mem_size,
  output logic [63:0]          proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]          mem2proc_data,
  output logic [4:0]           Dmem2proc_idx,
  output logic [7:0]           Dmem2proc_tag,
  output logic [63:0]          Dmem2proc_data,
  output logic                 Dmem2proc_valid,
  output logic                 mshr_full
);
  localparam logic [1:0] BUS_NONE    = 2'd0;
  localparam logic [1:0] BUS_LOAD    = 2'd1;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } mem_req_t;

  mem_req_t buf_q;
  logic     buf_vld;

  logic [N_MSHR-1:0]                ent_vld, alloc_oh, free_oh;
  logic [N_MSHR-1:0][MEM_TAG_W-1:0] ent_tag;
  logic [N_MSHR-1:0][28:0]          ent_blk;

  logic        is_load, merge_hit, take, issue_done, alloc_en, alloc_found, fill_hit;
  logic [28:0] fill_blk;

  assign is_load    = (proc2Dmem_command == BUS_LOAD);
  assign mshr_full  = &ent_vld;
  assign issue_done = buf_vld && (mem2proc_response != '0);
  assign alloc_en   = issue_done && (buf_q.cmd == BUS_LOAD);

`ifdef DMEM_MERGE_EN
  // a load to a block already in flight rides on that block's pending fill
  always_comb begin
    merge_hit = is_load && buf_vld && (buf_q.cmd == BUS_LOAD) &&
                (buf_q.addr[31:3] == proc2Dmem_addr[31:3]);
    for (int i = 0; i < N_MSHR; i++)
      if (is_load && ent_vld[i] && (ent_blk[i] == proc2Dmem_addr[31:3]))
        merge_hit = 1'b1;
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign req_ready = (proc2Dmem_command != BUS_NONE) &&
                     (merge_hit || (!buf_vld && !(is_load && mshr_full)));
  assign take      = req_ready && !merge_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_vld <= 1'b0;
      buf_q   <= '0;
    end else if (take) begin
      buf_vld <= 1'b1;
      buf_q   <= '{cmd: proc2Dmem_command, addr: proc2Dmem_addr,
                   size: proc2Dmem_size, data: proc2Dmem_data};
    end else if (issue_done) begin
      buf_vld <= 1'b0;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_size    = SIZE_DOUBLE;
    proc2mem_data    = '0;
    if (buf_vld) begin
      proc2mem_command = buf_q.cmd;
      proc2mem_addr    = buf_q.addr;
      proc2mem_size    = buf_q.size;
      proc2mem_data    = buf_q.data;
    end
  end

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < N_MSHR; i++)
      if (!ent_vld[i] && !alloc_found) begin
        alloc_oh[i] = alloc_en;
        alloc_found = 1'b1;
      end
  end

  always_comb begin
    free_oh  = '0;
    fill_hit = 1'b0;
    fill_blk = '0;
    for (int i = 0; i < N_MSHR; i++)
      if (!fill_hit && ent_vld[i] && (mem2proc_tag != '0) && (ent_tag[i] == mem2proc_tag)) begin
        free_oh[i] = 1'b1;
        fill_hit   = 1'b1;
        fill_blk   = ent_blk[i];
      end
  end

  genvar g;
  generate
    for (g = 0; g < N_MSHR; g++) begin : g_mshr
      dcache_mshr_entry #(.MEM_TAG_W(MEM_TAG_W)) u_ent (
        .clock     (clock),
        .reset     (reset),
        .alloc     (alloc_oh[g]),
        .free      (free_oh[g]),
        .alloc_tag (mem2proc_response),
        .alloc_blk (buf_q.addr[31:3]),
        .vld       (ent_vld[g]),
        .tag       (ent_tag[g]),
        .blk       (ent_blk[g])
      );
    end
  endgenerate

  // upper block-address bits only feed the merge compare
  logic unused_blk;
  assign unused_blk = ^fill_blk[28:13];

  always_ff @(posedge clock) begin
    if (reset) begin
      Dmem2proc_valid <= 1'b0;
      Dmem2proc_idx   <= '0;
      Dmem2proc_tag   <= '0;
      Dmem2proc_data  <= '0;
    end else begin
      Dmem2proc_valid <= fill_hit;
      Dmem2proc_idx   <= fill_blk[4:0];
      Dmem2proc_tag   <= fill_blk[12:5];
      Dmem2proc_data  <= fill_hit ? mem2proc_data : '0;
    end
  end
endmodule

// File: tb/tb_dcache_mem_fill.sv
// Directed bench for dcache_mem_fill: expected fills go to a scoreboard queue, a monitor
// pops and compares on every Dmem2proc_valid. Merge checks depend on DMEM_MERGE_EN.
module tb_dcache_mem_fill;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  proc2Dmem_command, proc2Dmem_size;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic        req_ready;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [4:0]  Dmem2proc_idx;
  logic [7:0]  Dmem2proc_tag;
  logic [63:0] Dmem2proc_data;
  logic        Dmem2proc_valid, mshr_full;

  dcache_mem_fill #(.N_MSHR(4), .MEM_TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_size(proc2Dmem_size), .proc2Dmem_data(proc2Dmem_data),
    .req_ready(req_ready),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .Dmem2proc_idx(Dmem2proc_idx), .Dmem2proc_tag(Dmem2proc_tag),
    .Dmem2proc_data(Dmem2proc_data), .Dmem2proc_valid(Dmem2proc_valid),
    .mshr_full(mshr_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  idx;
    logic [7:0]  tag;
    logic [63:0] data;
  } fill_t;

  fill_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // accept one request, check it on the bus, then have memory accept it with rtag
  task automatic issue(input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, input logic [3:0] rtag);
    proc2Dmem_command = cmd;
    proc2Dmem_addr    = addr;
    proc2Dmem_data    = data;
    #1 chk("issue_req_ready", 64'(req_ready), 64'd1);
    tick();
    proc2Dmem_command = 2'd0;
    chk("issue_bus_cmd", 64'(proc2mem_command), 64'(cmd));
    chk("issue_bus_addr", 64'(proc2mem_addr), 64'(addr));
    mem2proc_response = rtag;
    tick();
    mem2proc_response = 4'd0;
  endtask

  task automatic fill(input logic [3:0] tag, input logic [63:0] data,
                      input logic [4:0] eidx, input logic [7:0] etag);
    fill_t f;
    f.idx = eidx; f.tag = etag; f.data = data;
    sb.push_back(f);
    mem2proc_tag  = tag;
    mem2proc_data = data;
    tick();
    mem2proc_tag  = 4'd0;
    mem2proc_data = 64'd0;
  endtask

  always @(negedge clock) begin
    if (!reset && Dmem2proc_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_fill", 64'(Dmem2proc_idx), 64'hFFFF);
      end else begin
        fill_t e;
        e = sb.pop_front();
        chk("fill_idx", 64'(Dmem2proc_idx), 64'(e.idx));
        chk("fill_tag", 64'(Dmem2proc_tag), 64'(e.tag));
        chk("fill_data", Dmem2proc_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    proc2Dmem_command = 2'd0; proc2Dmem_addr = '0; proc2Dmem_size = 2'd3; proc2Dmem_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_cmd", 64'(proc2mem_command), 64'd0);
    chk("rst_size", 64'(proc2mem_size), 64'd3);
    chk("rst_addr", 64'(proc2mem_addr), 64'd0);
    chk("rst_data", proc2mem_data, 64'd0);
    chk("rst_fill_valid", 64'(Dmem2proc_valid), 64'd0);
    chk("rst_mshr_full", 64'(mshr_full), 64'd0);
    reset = 1'b0;

    // basic load miss: accept c0, bus c1, response c2, tag c6, fill c7
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h0000_1238;
    #1 chk("t1_req_ready", 64'(req_ready), 64'd1);
    tick();                                             // cycle 1
    proc2Dmem_command = 2'd0;
    chk("t1_bus_cmd", 64'(proc2mem_command), 64'd1);
    chk("t1_bus_addr", 64'(proc2mem_addr), 64'h1238);
    chk("t1_busy_ready", 64'(req_ready), 64'd0);
    tick();                                             // cycle 2
    mem2proc_response = 4'd3;
    tick();                                             // cycle 3
    mem2proc_response = 4'd0;
    chk("t1_bus_idle", 64'(proc2mem_command), 64'd0);
    tick(); tick(); tick();                             // cycle 6
    chk("t1_pre_fill", 64'(Dmem2proc_valid), 64'd0);
    fill(4'd3, 64'hDEADBEEF_CAFEF00D, 5'd7, 8'h12);     // cycle 7
    chk("t1_fill_c7", 64'(Dmem2proc_valid), 64'd1);
    tick();
    chk("t1_fill_c8", 64'(Dmem2proc_valid), 64'd0);

    // retries: response 0 three times, then 5
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h0000_2000;
    tick();
    proc2Dmem_command = 2'd0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_cmd", 64'(proc2mem_command), 64'd1);
      chk("t2_hold_addr", 64'(proc2mem_addr), 64'h2000);
      mem2proc_response = (i == 3) ? 4'd5 : 4'd0;
      tick();
    end
    mem2proc_response = 4'd0;
    chk("t2_done", 64'(proc2mem_command), 64'd0);
    fill(4'd5, 64'h5555_0000_AAAA_0001, 5'd0, 8'h20);

    // fill MSHR table, then free one entry
    issue(2'd1, 32'h0000_1008, 64'd0, 4'd1);
    issue(2'd1, 32'h0000_1110, 64'd0, 4'd2);
    issue(2'd1, 32'h0000_1218, 64'd0, 4'd3);
    issue(2'd1, 32'h0000_1320, 64'd0, 4'd4);
    chk("t3_full", 64'(mshr_full), 64'd1);
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h0000_1428;
    #1 chk("t3_blocked", 64'(req_ready), 64'd0);
    fill(4'd2, 64'h0000_0000_0000_0002, 5'd2, 8'h11);
    chk("t3_freed_ready", 64'(req_ready), 64'd1);
    chk("t3_not_full", 64'(mshr_full), 64'd0);
    tick();
    proc2Dmem_command = 2'd0;
    chk("t3_5th_addr", 64'(proc2mem_addr), 64'h1428);
    mem2proc_response = 4'd6;
    tick();
    mem2proc_response = 4'd0;
    chk("t3_full_again", 64'(mshr_full), 64'd1);
    fill(4'd1, 64'h0000_0000_0000_0001, 5'd1, 8'h10);
    fill(4'd3, 64'h0000_0000_0000_0003, 5'd3, 8'h12);
    fill(4'd4, 64'h0000_0000_0000_0004, 5'd4, 8'h13);
    fill(4'd6, 64'h0000_0000_0000_0006, 5'd5, 8'h14);
    chk("t3_drained", 64'(mshr_full), 64'd0);

    // store: issued once, untracked
    proc2Dmem_size = 2'd2;
    proc2Dmem_command = 2'd2; proc2Dmem_addr = 32'h40; proc2Dmem_data = 64'h1122334455667788;
    #1 chk("t4_ready", 64'(req_ready), 64'd1);
    tick();
    proc2Dmem_command = 2'd0;
    chk("t4_cmd", 64'(proc2mem_command), 64'd2);
    chk("t4_data", proc2mem_data, 64'h1122334455667788);
    chk("t4_size", 64'(proc2mem_size), 64'd2);
    mem2proc_response = 4'd2;
    tick();
    mem2proc_response = 4'd0;
    proc2Dmem_size = 2'd3;
    chk("t4_once", 64'(proc2mem_command), 64'd0);
    mem2proc_tag = 4'd2;
    tick();
    mem2proc_tag = 4'd0;
    chk("t4_no_fill", 64'(Dmem2proc_valid), 64'd0);

    // out-of-order return plus a stray tag
    issue(2'd1, 32'h0000_0100, 64'd0, 4'd4);
    issue(2'd1, 32'h0000_0200, 64'd0, 4'd1);
    fill(4'd1, 64'hAAAA_2000_0000_0200, 5'd0, 8'h02);
    fill(4'd4, 64'hBBBB_1000_0000_0100, 5'd0, 8'h01);
    mem2proc_tag = 4'd9;
    tick();
    mem2proc_tag = 4'd0;
    chk("t5_stray", 64'(Dmem2proc_valid), 64'd0);

    // two loads to the same block
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h300;
    tick();
    proc2Dmem_addr = 32'h304;
    mem2proc_response = 4'd7;
`ifdef DMEM_MERGE_EN
    #1 chk("t6_merge_ready", 64'(req_ready), 64'd1);
    tick();
    proc2Dmem_command = 2'd0;
    mem2proc_response = 4'd0;
    chk("t6_merge_no_issue", 64'(proc2mem_command), 64'd0);
    fill(4'd7, 64'h3030_3030_3030_3030, 5'd0, 8'h03);
`else
    #1 chk("t6_dup_blocked", 64'(req_ready), 64'd0);
    tick();
    mem2proc_response = 4'd0;
    chk("t6_dup_ready", 64'(req_ready), 64'd1);
    tick();
    proc2Dmem_command = 2'd0;
    chk("t6_dup_addr", 64'(proc2mem_addr), 64'h304);
    mem2proc_response = 4'd8;
    tick();
    mem2proc_response = 4'd0;
    fill(4'd7, 64'h3030_3030_3030_3030, 5'd0, 8'h03);
    fill(4'd8, 64'h3434_3434_3434_3434, 5'd0, 8'h03);
`endif

    // reset mid-operation drops the MSHR
    issue(2'd1, 32'h0000_0500, 64'd0, 4'd10);
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h600;
    tick();
    proc2Dmem_command = 2'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_bus_cleared", 64'(proc2mem_command), 64'd0);
    mem2proc_tag = 4'd10;
    tick();
    mem2proc_tag = 4'd0;
    chk("t7_no_fill", 64'(Dmem2proc_valid), 64'd0);

    tick(); tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
